btn_cond: RTL and testbench

//  N-channel front-panel input conditioner: synchronises raw buttons and switches,

---
 rtl/btn_cond_if.sv | 42 ++++
 rtl/btn_cond.sv | 134 +++++++++++++
 tb/tb_btn_cond.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_cond_if.sv
// btn_cond_if: signal bundle between the board-pin side and the input conditioner.
//   i_btn        raw asynchronous buttons
//   i_sw         raw asynchronous switches
//   i_repeat_en  per-channel auto-repeat enable
//   i_cnt_clr    clear press counter
//   o_tick       one-cycle sampling strobe
//   o_sw         switches captured on tick
//   o_btn_level  debounced button level
//   o_btn_rise   one-cycle press pulse (includes auto-repeat)
//   o_btn_fall   one-cycle release pulse
//   o_press_cnt  wrapping count of rise pulses on the counted channel
// Handshake: none of these signals carries valid/ready. The o_* pulses are
// single-cycle strobes with no backpressure; a consumer that is not looking
// in that cycle misses the event. Levels and o_sw hold until the next update.
interface btn_cond_if #(
    parameter int NUM_BTN   = 4,
    parameter int NUM_SW    = 8,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_BTN-1:0]   i_btn;
    logic [NUM_SW-1:0]    i_sw;
    logic [NUM_BTN-1:0]   i_repeat_en;
    logic                 i_cnt_clr;
    logic                 o_tick;
    logic [NUM_SW-1:0]    o_sw;
    logic [NUM_BTN-1:0]   o_btn_level;
    logic [NUM_BTN-1:0]   o_btn_rise;
    logic [NUM_BTN-1:0]   o_btn_fall;
    logic [CNT_WIDTH-1:0] o_press_cnt;

    // Board/test side drives the raw inputs and observes the results.
    modport master (
        output i_btn, i_sw, i_repeat_en, i_cnt_clr,
        input  o_tick, o_sw, o_btn_level, o_btn_rise, o_btn_fall, o_press_cnt
    );

    // Conditioner side.
    modport slave (
        input  i_btn, i_sw, i_repeat_en, i_cnt_clr,
        output o_tick, o_sw, o_btn_level, o_btn_rise, o_btn_fall, o_press_cnt
    );
endinterface

// File: rtl/btn_cond.sv
// btn_cond: N-channel front-panel input conditioner.
// Synchronises raw buttons/switches, derives a sampling tick from a free-running
// divider, debounces each button over DEB_DEPTH tick samples, emits one-cycle
// rise/fall pulses with optional per-channel auto-repeat, and counts presses on
// channel CNT_CH.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  btn_cond_if.slave (raw inputs in, conditioned outputs out)
module btn_cond #(
    parameter int NUM_BTN     = 4,
    parameter int NUM_SW      = 8,
    parameter int DIV_WIDTH   = 17,
    parameter int DEB_DEPTH   = 3,
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8,
    parameter int CNT_CH      = 0,
    parameter int CNT_WIDTH   = 8
) (
    input logic     clk,
    input logic     rst,
    btn_cond_if.slave bus
);
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_V  = REP_W'(REPEAT_DLY);
    localparam logic [REP_W-1:0] REP_RATE_V = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

    logic [NUM_BTN-1:0]   btn_s1, btn_s2;
    logic [NUM_SW-1:0]    sw_s1, sw_s2;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick, tick_d;
    logic [DEB_DEPTH-1:0] shreg [NUM_BTN];
    logic [REP_W-1:0]     rep_cnt [NUM_BTN];
    logic [NUM_BTN-1:0]   level, rise, fall;
    logic [NUM_SW-1:0]    sw_q;
    logic [CNT_WIDTH-1:0] press_cnt;

    logic [NUM_BTN-1:0]   new_level;
    logic [NUM_BTN-1:0]   rep_hit;
    logic [REP_W-1:0]     rep_next [NUM_BTN];

    // Level/repeat decisions, only consumed in the tick_d cycle. The new level
    // is decided first, so a channel that is falling never sees a repeat pulse.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            new_level[i] = level[i];
            rep_hit[i]   = 1'b0;
            rep_next[i]  = REP_DLY_V;
            if (&shreg[i]) begin
                new_level[i] = 1'b1;
            end else if (~|shreg[i]) begin
                new_level[i] = 1'b0;
            end
            if (new_level[i] && !level[i]) begin
                rep_next[i] = REP_DLY_V;
            end else if (new_level[i] && bus.i_repeat_en[i]) begin
                if (rep_cnt[i] == REP_ONE) begin
                    rep_hit[i]  = 1'b1;
                    rep_next[i] = REP_RATE_V;
                end else begin
                    rep_next[i] = rep_cnt[i] - REP_ONE;
                end
            end else begin
                // Released or repeat disabled: re-arm the full initial delay.
                rep_next[i] = REP_DLY_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            div_cnt   <= '0;
            tick      <= 1'b0;
            tick_d    <= 1'b0;
            level     <= '0;
            rise      <= '0;
            fall      <= '0;
            sw_q      <= '0;
            press_cnt <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                shreg[i]   <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            btn_s1  <= bus.i_btn;
            btn_s2  <= btn_s1;
            sw_s1   <= bus.i_sw;
            sw_s2   <= sw_s1;
            div_cnt <= div_cnt + 1'b1;
            // Registered so the strobe sits in the cycle the counter reads 0.
            tick    <= (div_cnt == '1);
            tick_d  <= tick;

            if (tick) begin
                sw_q <= sw_s2;
                for (int i = 0; i < NUM_BTN; i++) begin
                    shreg[i] <= {shreg[i][DEB_DEPTH-2:0], btn_s2[i]};
                end
            end

            if (tick_d) begin
                level <= new_level;
                rise  <= (new_level & ~level) | rep_hit;
                fall  <= level & ~new_level;
                for (int i = 0; i < NUM_BTN; i++) begin
                    rep_cnt[i] <= rep_next[i];
                end
            end else begin
                rise <= '0;
                fall <= '0;
            end

            // Clear beats a coincident press.
            if (bus.i_cnt_clr) begin
                press_cnt <= '0;
            end else if (rise[CNT_CH]) begin
                press_cnt <= press_cnt + 1'b1;
            end
        end
    end

    assign bus.o_tick      = tick;
    assign bus.o_sw        = sw_q;
    assign bus.o_btn_level = level;
    assign bus.o_btn_rise  = rise;
    assign bus.o_btn_fall  = fall;
    assign bus.o_press_cnt = press_cnt;
endmodule

// File: tb/tb_btn_cond.sv
module tb_btn_cond;
  localparam int NB   = 4;
  localparam int NSW  = 8;
  localparam int DIVW = 4;
  localparam int DEB  = 3;
  localparam int DLY  = 4;
  localparam int RATE = 2;
  localparam int CH   = 0;
  localparam int CW   = 8;
  localparam int P    = 1 << DIVW;
  localparam int EW   = 32 + 3 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_cond_if #(.NUM_BTN(NB), .NUM_SW(NSW), .CNT_WIDTH(CW)) bus ();

  btn_cond #(
    .NUM_BTN(NB), .NUM_SW(NSW), .DIV_WIDTH(DIVW), .DEB_DEPTH(DEB),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .CNT_CH(CH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works per tick: the button value presented to tick m is whatever was on
  // the pin at cycle 16m-1 after reset release (two-stage synchroniser); the
  // decision for tick m becomes visible after cycle 16m+2.
  logic [EW-1:0]  exp_q[$];
  logic [NB-1:0]  hist[$];
  logic [NB-1:0]  m_level;
  int             t0[NB];
  int             ecount = 0;
  int             tick_m = 0;
  bit             active = 0;
  bit             in_rst = 0;
  bit             pend = 0;
  logic [CW-1:0]  m_cnt;
  logic [NSW-1:0] sw_samp, m_sw;

  task automatic evaluate(input logic [NB-1:0] en);
    logic [NB-1:0] rv, fv, nl;
    bit all1, all0;
    int n;
    rv = '0;
    fv = '0;
    nl = m_level;
    tick_m++;
    for (int i = 0; i < NB; i++) begin
      all1 = 1;
      all0 = 1;
      foreach (hist[k]) begin
        if (hist[k][i]) all0 = 0;
        else all1 = 0;
      end
      if (all1) nl[i] = 1'b1;
      else if (all0) nl[i] = 1'b0;
      if (nl[i] && !m_level[i]) begin
        rv[i] = 1'b1;
        t0[i] = tick_m;
      end else if (!nl[i] && m_level[i]) begin
        fv[i] = 1'b1;
      end else if (nl[i]) begin
        if (!en[i]) begin
          t0[i] = tick_m;
        end else begin
          n = tick_m - t0[i];
          if (n == DLY || (n > DLY && ((n - DLY) % RATE) == 0)) rv[i] = 1'b1;
        end
      end
    end
    m_level = nl;
    if ((rv | fv) != '0) exp_q.push_back({ecount, nl, fv, rv});
    if (rv[CH]) pend = 1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      active = 1;
      in_rst = 1;
      ecount = 0;
      tick_m = 0;
      hist.delete();
      for (int k = 0; k < DEB; k++) hist.push_back('0);
      m_level = '0;
      m_cnt = '0;
      pend = 0;
      m_sw = '0;
      sw_samp = '0;
      exp_q.delete();
      for (int i = 0; i < NB; i++) t0[i] = 0;
    end else if (active) begin
      in_rst = 0;
      ecount++;
      if (bus.i_cnt_clr) m_cnt = '0;
      else if (pend) m_cnt = m_cnt + 1'b1;
      pend = 0;
      if (ecount % P == P - 1) begin
        hist.push_back(bus.i_btn);
        void'(hist.pop_front());
        sw_samp = bus.i_sw;
      end
      if (ecount % P == 1 && ecount > P) m_sw = sw_samp;
      if (ecount % P == 2 && ecount > P) evaluate(bus.i_repeat_en);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (active && in_rst) begin
      check("reset_outputs", {bus.o_tick, bus.o_sw, bus.o_btn_level, bus.o_btn_rise,
                              bus.o_btn_fall, bus.o_press_cnt}, '0);
    end else if (active) begin
      check("tick", bus.o_tick, (ecount % P == 0));
      check("press_cnt", bus.o_press_cnt, m_cnt);
      if (ecount % P == 1 && ecount > P) check("sw", bus.o_sw, m_sw);
      if (ecount % P == 2 && ecount > P) check("level", bus.o_btn_level, m_level);
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1:3*NB]) < ecount) begin
        e = exp_q.pop_front();
        check("missed_pulse", '0, {e[2*NB-1:NB], e[NB-1:0]});
      end
      if ((bus.o_btn_rise | bus.o_btn_fall) != '0) begin
        if (exp_q.size() == 0 || int'(exp_q[0][EW-1:3*NB]) != ecount) begin
          check("unexpected_pulse", {bus.o_btn_rise, bus.o_btn_fall}, '0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_rise", bus.o_btn_rise, e[NB-1:0]);
          check("pulse_fall", bus.o_btn_fall, e[2*NB-1:NB]);
          check("pulse_level", bus.o_btn_level, e[3*NB-1:2*NB]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rise(input int ch, input int limit, output int n);
    n = 0;
    while (!bus.o_btn_rise[ch] && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rise_within_limit", (n < limit), 1'b1);
  endtask

  task automatic press(input int ch, input int hold_ticks, input int rel_ticks);
    bus.i_btn[ch] = 1'b1;
    repeat (hold_ticks * P) @(negedge clk);
    bus.i_btn[ch] = 1'b0;
    repeat (rel_ticks * P) @(negedge clk);
  endtask

  task automatic count_repeats(input int ch, output int cnt);
    int n;
    cnt = 0;
    bus.i_btn[ch] = 1'b1;
    wait_rise(ch, 8 * P, n);
    if (bus.o_btn_rise[ch]) cnt = 1;
    repeat (12 * P + 1) begin
      @(negedge clk);
      if (bus.o_btn_rise[ch]) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    bus.i_btn = '0;
    bus.i_sw = '0;
    bus.i_repeat_en = '0;
    bus.i_cnt_clr = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // first tick 16 cycles after release
    n = 0;
    while (!bus.o_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_delay", n, P);
    repeat (2 * P) @(negedge clk);

    // bouncing button 0, then held
    for (int k = 0; k < 20; k++) begin
      bus.i_btn[0] = ~bus.i_btn[0];
      repeat (5) @(negedge clk);
    end
    bus.i_btn[0] = 1'b1;
    repeat (8 * P) @(negedge clk);
    check("bounce_press_cnt", bus.o_press_cnt, 1);
    bus.i_btn[0] = 1'b0;
    repeat (6 * P) @(negedge clk);

    // auto-repeat on channel 1, enabled then disabled
    bus.i_repeat_en[1] = 1'b1;
    count_repeats(1, cnt);
    check("repeat_en_pulses", cnt, 6);
    bus.i_btn[1] = 1'b0;
    repeat (6 * P) @(negedge clk);
    bus.i_repeat_en[1] = 1'b0;
    count_repeats(1, cnt);
    check("repeat_dis_pulses", cnt, 1);
    bus.i_btn[1] = 1'b0;
    repeat (6 * P) @(negedge clk);

    // switch capture
    bus.i_sw = 8'hA5;
    repeat (P + 3) @(negedge clk);
    check("sw_a5", bus.o_sw, 8'hA5);

    // press counter wrap
    bus.i_cnt_clr = 1'b1;
    @(negedge clk);
    bus.i_cnt_clr = 1'b0;
    for (int k = 0; k < 256; k++) press(0, 4, 4);
    check("press_cnt_wrap", bus.o_press_cnt, 0);
    press(0, 4, 4);
    press(0, 4, 4);
    check("press_cnt_two", bus.o_press_cnt, 2);
    bus.i_btn[0] = 1'b1;
    wait_rise(0, 8 * P, n);
    bus.i_cnt_clr = 1'b1;
    @(negedge clk);
    bus.i_cnt_clr = 1'b0;
    check("clr_beats_rise", bus.o_press_cnt, 0);
    bus.i_btn[0] = 1'b0;
    repeat (6 * P) @(negedge clk);

    // randomized mix
    for (int k = 0; k < 300; k++) begin
      bus.i_btn = NB'($urandom);
      bus.i_repeat_en = NB'($urandom);
      bus.i_sw = NSW'($urandom);
      bus.i_cnt_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      bus.i_cnt_clr = 1'b0;
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    bus.i_btn = '0;
    bus.i_repeat_en = '0;
    repeat (6 * P) @(negedge clk);

    // reset while channel 2 is held
    bus.i_btn[2] = 1'b1;
    wait_rise(2, 8 * P, n);
    repeat (2 * P) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!bus.o_btn_rise[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rise_after_reset", n, 3 * P + 2);
    bus.i_btn[2] = 1'b0;
    repeat (6 * P) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
